// File: rtl/cpu_pkg.sv
// Shared constants and types for the 16-bit CPU front end.
package cpu_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;

  localparam logic [ADDR_W-1:0] PC_STEP  = 8'd2;
  localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

  // Instruction field positions used by decode.
  localparam int OPCODE_LSB = 12;
  localparam int OPCODE_W   = 4;
  localparam int FUNCT_LSB  = 0;
  localparam int FUNCT_W    = 4;
  localparam int OFFSET_LSB = 0;
  localparam int OFFSET_W   = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  // Instructions are halfword aligned: the low address bit is always zero.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
    return a & {{(ADDR_W-1){1'b1}}, 1'b0};
  endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: load, hold, flush, plus decode field slices.
module ifid_reg
  import cpu_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic                flush_i,
  input  logic [INSTR_W-1:0]  instr_i,
  input  logic [ADDR_W-1:0]   pc_i,
  output logic                valid_o,
  output logic [INSTR_W-1:0]  instr_o,
  output logic [ADDR_W-1:0]   pc_o,
  output logic [ADDR_W-1:0]   pc_next_o,
  output logic [OPCODE_W-1:0] opcode_o,
  output logic [FUNCT_W-1:0]  funct_o,
  output logic [OFFSET_W-1:0] offset_o
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;

  // Flush only kills the valid bit; data is kept since nothing reads it while invalid.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end
  end

  // Register with immediate clear on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= RESET_PC;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o   = valid_q;
  assign instr_o   = instr_q;
  assign pc_o      = pc_q;
  assign pc_next_o = pc_q + PC_STEP;
  assign opcode_o  = instr_q[OPCODE_LSB +: OPCODE_W];
  assign funct_o   = instr_q[FUNCT_LSB  +: FUNCT_W];
  assign offset_o  = instr_q[OFFSET_LSB +: OFFSET_W];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC ownership, imem request/ack handshake, stall skid, branch redirect.
module fetch_stage
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic                ifid_valid,
  output logic [INSTR_W-1:0]  ifid_instr,
  output logic [ADDR_W-1:0]   ifid_pc,
  output logic [ADDR_W-1:0]   ifid_pc_next,
  output logic [OPCODE_W-1:0] ifid_opcode,
  output logic [FUNCT_W-1:0]  ifid_funct,
  output logic [OFFSET_W-1:0] ifid_offset
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               pend_q, pend_d;
  logic [ADDR_W-1:0]  pend_pc_q, pend_pc_d;
  logic [INSTR_W-1:0] skid_q, skid_d;

  logic               ifid_load;
  logic               ifid_flush;
  logic [INSTR_W-1:0] ifid_src_instr;

  // Next-state logic. A redirect during an outstanding request is parked in
  // pend_pc so the address stays stable until the memory answers.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    pend_d         = pend_q;
    pend_pc_d      = pend_pc_q;
    skid_d         = skid_q;
    ifid_load      = 1'b0;
    ifid_flush     = 1'b0;
    ifid_src_instr = imem_rdata;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect) begin
          pc_d       = align_pc(redirect_pc);
          ifid_flush = 1'b1;
        end
      end

      FETCH: begin
        if (imem_ack) begin
          if (redirect || pend_q) begin
            pc_d       = redirect ? align_pc(redirect_pc) : align_pc(pend_pc_q);
            pend_d     = 1'b0;
            ifid_flush = 1'b1;
          end else if (stall) begin
            skid_d  = imem_rdata;
            state_d = HOLD;
          end else begin
            ifid_load = 1'b1;
            pc_d      = pc_q + PC_STEP;
          end
        end else if (redirect) begin
          pend_d     = 1'b1;
          pend_pc_d  = redirect_pc;
          ifid_flush = 1'b1;
        end else if (!stall) begin
          ifid_flush = 1'b1;
        end
      end

      HOLD: begin
        if (redirect) begin
          skid_d     = '0;
          pc_d       = align_pc(redirect_pc);
          ifid_flush = 1'b1;
          state_d    = FETCH;
        end else if (!stall) begin
          ifid_load      = 1'b1;
          ifid_src_instr = skid_q;
          pc_d           = pc_q + PC_STEP;
          state_d        = FETCH;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Fetch control state, cleared immediately on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= RESET_PC;
      skid_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      skid_q    <= skid_d;
    end
  end

  assign imem_req  = (state_q == FETCH);
  assign imem_addr = pc_q;

  ifid_reg u_ifid (
    .clk_i     (clk),
    .rst_ni    (reset),
    .load_i    (ifid_load),
    .flush_i   (ifid_flush),
    .instr_i   (ifid_src_instr),
    .pc_i      (pc_q),
    .valid_o   (ifid_valid),
    .instr_o   (ifid_instr),
    .pc_o      (ifid_pc),
    .pc_next_o (ifid_pc_next),
    .opcode_o  (ifid_opcode),
    .funct_o   (ifid_funct),
    .offset_o  (ifid_offset)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory responder, behavioural model, per-cycle compare, directed checks.
module tb_fetch_stage;
  import cpu_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         stall;
  logic         redirect;
  logic [7:0]   redirect_pc;
  logic         imem_req;
  logic [7:0]   imem_addr;
  logic         imem_ack = 1'b0;
  logic [15:0]  imem_rdata = 16'h0000;
  logic         ifid_valid;
  logic [15:0]  ifid_instr;
  logic [7:0]   ifid_pc;
  logic [7:0]   ifid_pc_next;
  logic [3:0]   ifid_opcode;
  logic [3:0]   ifid_funct;
  logic [11:0]  ifid_offset;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .ifid_valid   (ifid_valid),
    .ifid_instr   (ifid_instr),
    .ifid_pc      (ifid_pc),
    .ifid_pc_next (ifid_pc_next),
    .ifid_opcode  (ifid_opcode),
    .ifid_funct   (ifid_funct),
    .ifid_offset  (ifid_offset)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory: answers after 'lat' wait cycles with 16'h1000+addr.
  // 'spur' drives a stray ack while no request is outstanding.
  int lat = 0;
  int cur_wait = 0;
  bit spur = 1'b0;

  always @(negedge clk) begin
    if (imem_req === 1'b1) begin
      if (cur_wait >= lat) begin
        imem_ack   = 1'b1;
        imem_rdata = 16'h1000 + {8'h00, imem_addr};
        cur_wait   = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 16'hDEAD;
        cur_wait   = cur_wait + 1;
      end
    end else begin
      imem_ack   = spur;
      imem_rdata = 16'hBAD0;
      cur_wait   = 0;
    end
  end

  // Behavioural model: what IF/ID and the fetch port must show, from the stage rules.
  bit          m_starting = 1'b1;  // first cycle after reset: no request yet
  bit          m_holding  = 1'b0;  // an instruction is parked waiting for decode
  bit          m_pend     = 1'b0;
  logic [7:0]  m_pend_pc  = 8'h00;
  logic [7:0]  m_pc       = 8'h00;
  logic [15:0] m_parked   = 16'h0000;
  bit          m_v        = 1'b0;
  logic [15:0] m_instr    = 16'h0000;
  logic [7:0]  m_ipc      = 8'h00;

  function automatic logic [7:0] even(input logic [7:0] a);
    return 8'((int'(a) / 2) * 2);
  endfunction

  function automatic logic [7:0] plus2(input logic [7:0] a);
    return 8'((int'(a) + 2) % 256);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_starting = 1'b1; m_holding = 1'b0; m_pend = 1'b0; m_pend_pc = 8'h00;
      m_pc = 8'h00; m_parked = 16'h0000; m_v = 1'b0; m_instr = 16'h0000; m_ipc = 8'h00;
    end else if (m_starting) begin
      m_starting = 1'b0;
      if (redirect) begin m_pc = even(redirect_pc); m_v = 1'b0; end
    end else if (m_holding) begin
      if (redirect) begin
        m_pc = even(redirect_pc); m_v = 1'b0; m_holding = 1'b0;
      end else if (!stall) begin
        m_instr = m_parked; m_ipc = m_pc; m_v = 1'b1; m_pc = plus2(m_pc); m_holding = 1'b0;
      end
    end else if (imem_ack) begin
      if (redirect || m_pend) begin
        m_pc = redirect ? even(redirect_pc) : even(m_pend_pc); m_pend = 1'b0; m_v = 1'b0;
      end else if (stall) begin
        m_parked = imem_rdata; m_holding = 1'b1;
      end else begin
        m_instr = imem_rdata; m_ipc = m_pc; m_v = 1'b1; m_pc = plus2(m_pc);
      end
    end else if (redirect) begin
      m_pend = 1'b1; m_pend_pc = redirect_pc; m_v = 1'b0;
    end else if (!stall) begin
      m_v = 1'b0;
    end
  end

  // Per-cycle compare of every output against the model.
  always @(posedge clk) begin
    #1;
    chk("req",     32'(imem_req),     32'(!m_starting && !m_holding && reset));
    chk("addr",    32'(imem_addr),    32'(m_pc));
    chk("valid",   32'(ifid_valid),   32'(m_v));
    chk("instr",   32'(ifid_instr),   32'(m_instr));
    chk("pc",      32'(ifid_pc),      32'(m_ipc));
    chk("pc_next", 32'(ifid_pc_next), 32'(plus2(m_ipc)));
    chk("opcode",  32'(ifid_opcode),  32'(m_instr[15:12]));
    chk("funct",   32'(ifid_funct),   32'(m_instr[3:0]));
    chk("offset",  32'(ifid_offset),  32'(m_instr[11:0]));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Hand-computed literal against both the DUT and the model.
  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] mdl,
                     input logic [31:0] exp);
    chk(name, act, exp);
    chk({name, "_model"}, mdl, exp);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req"},     32'(imem_req),     32'h0);
    chk({tag, "_addr"},    32'(imem_addr),    32'h00);
    chk({tag, "_valid"},   32'(ifid_valid),   32'h0);
    chk({tag, "_instr"},   32'(ifid_instr),   32'h0000);
    chk({tag, "_pc"},      32'(ifid_pc),      32'h00);
    chk({tag, "_pc_next"}, 32'(ifid_pc_next), 32'h02);
  endtask

  typedef struct {
    bit         st;
    bit         rd;
    logic [7:0] tgt;
    int         lt;
  } vec_t;

  vec_t tbl [16] = '{
    '{1'b0, 1'b0, 8'h00, 0}, '{1'b1, 1'b0, 8'h00, 0}, '{1'b1, 1'b1, 8'h33, 0},
    '{1'b0, 1'b0, 8'h00, 1}, '{1'b1, 1'b0, 8'h00, 1}, '{1'b0, 1'b0, 8'h00, 1},
    '{1'b0, 1'b1, 8'h81, 2}, '{1'b0, 1'b1, 8'h90, 2}, '{1'b0, 1'b0, 8'h00, 2},
    '{1'b1, 1'b0, 8'h00, 0}, '{1'b0, 1'b0, 8'h00, 0}, '{1'b1, 1'b0, 8'h00, 0},
    '{1'b1, 1'b1, 8'hFC, 0}, '{1'b0, 1'b0, 8'h00, 0}, '{1'b1, 1'b0, 8'h00, 1},
    '{1'b0, 1'b0, 8'h00, 0}
  };

  initial begin
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
    repeat (2) step();
    check_reset_values("rst0");

    // Release reset; zero-wait memory streams 1000, 1002, 1004.
    reset = 1'b1;
    step();
    lit("first_req",  32'(imem_req),  32'(!m_starting && !m_holding), 32'h1);
    lit("first_addr", 32'(imem_addr), 32'(m_pc), 32'h00);
    step();
    lit("s0_pc",    32'(ifid_pc),    32'(m_ipc),   32'h00);
    lit("s0_instr", 32'(ifid_instr), 32'(m_instr), 32'h1000);
    step();
    lit("s1_pc",    32'(ifid_pc),    32'(m_ipc),   32'h02);
    lit("s1_instr", 32'(ifid_instr), 32'(m_instr), 32'h1002);
    step();
    lit("s2_pc",    32'(ifid_pc),    32'(m_ipc),   32'h04);
    lit("s2_instr", 32'(ifid_instr), 32'(m_instr), 32'h1004);

    // Stall for three edges while the 06 fetch is acked; stray acks while holding.
    stall = 1'b1; spur = 1'b1;
    step();
    chk("hold_req", 32'(imem_req), 32'h0);
    lit("hold_pc",  32'(ifid_pc),  32'(m_ipc), 32'h04);
    step(); step();
    lit("hold3_pc", 32'(ifid_pc),  32'(m_ipc), 32'h04);
    stall = 1'b0; spur = 1'b0;
    step();
    lit("rel_pc",    32'(ifid_pc),    32'(m_ipc),   32'h06);
    lit("rel_instr", 32'(ifid_instr), 32'(m_instr), 32'h1006);
    lit("rel_addr",  32'(imem_addr),  32'(m_pc),    32'h08);
    chk("rel_req",   32'(imem_req),   32'h1);

    // Redirect to odd target 41 in an ack cycle.
    redirect = 1'b1; redirect_pc = 8'h41;
    step();
    redirect = 1'b0;
    lit("br_valid", 32'(ifid_valid), 32'(m_v),  32'h0);
    lit("br_addr",  32'(imem_addr),  32'(m_pc), 32'h40);
    step();
    lit("br_pc",    32'(ifid_pc),    32'(m_ipc),   32'h40);
    lit("br_instr", 32'(ifid_instr), 32'(m_instr), 32'h1040);

    // Three-cycle latency, redirect to 20 in the first wait cycle.
    lat = 2; redirect = 1'b1; redirect_pc = 8'h20;
    step();
    redirect = 1'b0;
    lit("w1_addr",  32'(imem_addr),  32'(m_pc), 32'h42);
    lit("w1_valid", 32'(ifid_valid), 32'(m_v),  32'h0);
    step();
    lit("w2_addr",  32'(imem_addr),  32'(m_pc), 32'h42);
    step();
    lit("w3_addr",  32'(imem_addr),  32'(m_pc), 32'h20);
    lit("w3_valid", 32'(ifid_valid), 32'(m_v),  32'h0);
    lat = 0;
    step();
    lit("w4_pc",    32'(ifid_pc),    32'(m_ipc),   32'h20);
    lit("w4_instr", 32'(ifid_instr), 32'(m_instr), 32'h1020);

    // PC wrap at FE.
    redirect = 1'b1; redirect_pc = 8'hFE;
    step();
    redirect = 1'b0;
    lit("fe_addr", 32'(imem_addr), 32'(m_pc), 32'hFE);
    step();
    lit("fe_pc",      32'(ifid_pc),      32'(m_ipc),        32'hFE);
    lit("fe_pc_next", 32'(ifid_pc_next), 32'(plus2(m_ipc)), 32'h00);
    lit("fe_addr2",   32'(imem_addr),    32'(m_pc),         32'h00);
    chk("fe_instr",   32'(ifid_instr),   32'h10FE);
    step();
    lit("wrap_pc",    32'(ifid_pc),      32'(m_ipc),   32'h00);
    lit("wrap_instr", 32'(ifid_instr),   32'(m_instr), 32'h1000);

    // Reset during an outstanding request.
    lat = 3;
    step();
    chk("out_req",  32'(imem_req),  32'h1);
    chk("out_addr", 32'(imem_addr), 32'h02);
    #1 reset = 1'b0;
    #1 check_reset_values("rst_req");
    step();
    lat = 0; reset = 1'b1;
    step();
    chk("rs_req",  32'(imem_req),  32'h1);
    chk("rs_addr", 32'(imem_addr), 32'h00);
    step();
    lit("rs_pc",    32'(ifid_pc),    32'(m_ipc),   32'h00);
    lit("rs_instr", 32'(ifid_instr), 32'(m_instr), 32'h1000);

    // Reset during HOLD.
    stall = 1'b1;
    step();
    chk("h_req", 32'(imem_req), 32'h0);
    #1 reset = 1'b0;
    #1 check_reset_values("rst_hold");
    stall = 1'b0;
    step();
    reset = 1'b1;
    step(); step();
    lit("rh_pc",    32'(ifid_pc),    32'(m_ipc),   32'h00);
    lit("rh_instr", 32'(ifid_instr), 32'(m_instr), 32'h1000);

    // Mixed stall/redirect/latency sequence checked by the model each cycle.
    for (int i = 0; i < 16; i++) begin
      stall = tbl[i].st; redirect = tbl[i].rd; redirect_pc = tbl[i].tgt; lat = tbl[i].lt;
      step();
    end
    stall = 1'b0; redirect = 1'b0; lat = 0;
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage for the 16-bit pipelined CPU: owns the 8-bit PC, issues requests to instruction memory over a request/acknowledge handshake, and loads the IF/ID pipeline register feeding decode (control, RegFile, sign extension). It advances the PC by 2 per instruction, holds on a decode stall, and redirects on a taken branch from EX with IF/ID flush.

## Interface
- ADDR_W, 8, PC and instruction-memory address width
- INSTR_W, 16, instruction width
- PC_STEP, 2, PC increment per instruction
- RESET_PC, 8'h00, PC value after reset
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- stall  in  1  decode cannot accept; IF/ID holds contents
- redirect  in  1  taken branch/jump; flush and refetch
- redirect_pc  in  ADDR_W  branch target; bit 0 ignored (forced 0)
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch address, equal to PC
- imem_ack  in  1  response valid this cycle; may arrive in the request cycle
- imem_rdata  in  INSTR_W  instruction, valid with imem_ack
- ifid_valid  out  1  IF/ID holds a live instruction
- ifid_instr  out  INSTR_W  fetched instruction
- ifid_pc  out  ADDR_W  address of ifid_instr
- ifid_pc_next  out  ADDR_W  ifid_pc + PC_STEP (mod 2^ADDR_W)
- ifid_opcode  out  4  ifid_instr[15:12]
- ifid_funct  out  4  ifid_instr[3:0]
- ifid_offset  out  12  ifid_instr[11:0]

## Operation
- States: IDLE, FETCH, HOLD. Reset enters IDLE; IDLE → FETCH unconditionally next cycle.
- imem_req = 1 only in FETCH; imem_addr = pc always.
- FETCH, no ack: req/addr held stable. If redirect: latch target in pend_pc, set pend flag; IF/ID flushed (ifid_valid←0). A later redirect overwrites pend_pc.
- FETCH, ack, pend set or redirect this cycle: response discarded; pc←(redirect ? redirect_pc : pend_pc) with bit 0 cleared; pend←0; stay FETCH; ifid_valid←0.
- FETCH, ack, no stall: IF/ID←{imem_rdata, pc}, ifid_valid←1, pc←pc+PC_STEP.
- FETCH, ack, stall: response captured in skid register, → HOLD; pc unchanged; IF/ID unchanged.
- HOLD: no request. !stall: IF/ID←skid, ifid_valid←1, pc←pc+PC_STEP, → FETCH. redirect: skid dropped, pc←redirect_pc, ifid_valid←0, → FETCH.
- FETCH with stall=1 and no ack: IF/ID unchanged. No ack and stall=0: ifid_valid←0 (bubble).
- Priority per cycle: reset > redirect > stall > normal.
- PC arithmetic modulo 2^ADDR_W: 8'hFE + 2 = 8'h00, no flag.
- At most one outstanding request; imem_ack outside FETCH ignored.

## Timing
- Reset values: pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, ifid_valid=0, ifid_instr=16'h0000, ifid_pc=RESET_PC, ifid_pc_next=RESET_PC+PC_STEP, pend=0, skid cleared.
- First request one cycle after reset release (IDLE).
- Zero-wait memory (ack in request cycle): one instruction into IF/ID per cycle; latency request→ifid_valid = 1 edge.
- N-cycle ack: IF/ID updates on the edge of the ack cycle.
- Redirect: IF/ID invalid next edge; first target instruction in IF/ID one edge after the target's ack (branch penalty ≥ 2 cycles at zero wait).
- Stall release from HOLD: skid instruction in IF/ID next edge; new request the cycle after.
- Reset asserted mid-request: req drops immediately (async), pending response forgotten.

## Structure
- Shared package cpu_pkg: ADDR_W, INSTR_W, PC_STEP, RESET_PC, fetch-state enum (IDLE/FETCH/HOLD), opcode/funct/offset field positions.
- One sub-module: ifid_reg (IF/ID register with load, hold, flush, async active-low clear), reused for field decode outputs.

## Test plan
- Reset release, zero-wait memory returning 16'h1000+addr: ifid_pc 00,02,04… on consecutive cycles, ifid_instr 1000,1002,1004.
- stall high 3 cycles while ack present: IF/ID holds, state HOLD, imem_req=0; on release skid instruction appears next edge, PC advances once.
- redirect to 8'h41 with ack: ifid_valid=0 next edge, imem_addr=8'h40, data from old PC never reaches IF/ID.
- 3-cycle ack latency, redirect in wait cycle 1 to 8'h20: imem_addr stays stable until ack, response dropped, next request at 8'h20.
- PC at 8'hFE, zero-wait: ifid_pc=FE, ifid_pc_next=00, next fetch addr 00.
- reset pulsed low during outstanding request and during HOLD: all outputs return to reset values immediately; fetch restarts at RESET_PC after IDLE.
